// File: rtl/bcd_seg_display.sv
// rtl/bcd_seg_display.sv - binary-to-BCD converter with multiplexed 4-digit 7-segment driver
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module bcd_seg_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        value_valid,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic [15:0] bcd_q;
  logic        ovf_q;
  logic [13:0] sh_q;
  logic [19:0] acc_q;
  logic [3:0]  iter_q;
  logic        big_q;

  logic [19:0] acc_adj_d;
  logic [19:0] acc_d;
  logic [13:0] sh_d;

  logic [CNT_W-1:0] refresh_q;
  logic [1:0]       dig_q;

  logic [3:0] nib_d;
  logic       blank_d;
  logic [6:0] seg_d;

  // Add-3 correction on every nibble >= 5, then one left shift of {acc, sh}.
  always_comb begin
    acc_adj_d = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) begin
        acc_adj_d[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      end
    end
    acc_d = {acc_adj_d[18:0], sh_q[13]};
    sh_d  = {sh_q[12:0], 1'b0};
  end

  // Conversion FSM: load on strobe, 14 shift-add-3 iterations, commit on the last.
  // A strobe on the commit edge starts the next conversion directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      sh_q    <= 14'd0;
      acc_q   <= 20'd0;
      iter_q  <= 4'd0;
      big_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (value_valid) begin
            sh_q    <= value;
            acc_q   <= 20'd0;
            iter_q  <= 4'd0;
            big_q   <= (value > 14'd9999);
            state_q <= CONV;
            busy_q  <= 1'b1;
          end
        end
        CONV: begin
          acc_q  <= acc_d;
          sh_q   <= sh_d;
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd13) begin
            bcd_q <= acc_d[15:0];
            ovf_q <= (acc_d[19:16] != 4'd0) || big_q;
            if (value_valid) begin
              sh_q    <= value;
              acc_q   <= 20'd0;
              iter_q  <= 4'd0;
              big_q   <= (value > 14'd9999);
              state_q <= CONV;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running refresh divider; the digit index advances on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      dig_q     <= 2'd0;
    end else if (refresh_q == CNT_LAST) begin
      refresh_q <= '0;
      dig_q     <= dig_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Select the scanned nibble and decide blanking; seg is derived from the
  // same index register as an, so both switch on the same edge.
  always_comb begin
    nib_d   = bcd_q[dig_q*4 +: 4];
    blank_d = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (dig_q)
      2'd3:    blank_d = (bcd_q[15:12] == 4'd0);
      2'd2:    blank_d = (bcd_q[15:8] == 8'd0);
      2'd1:    blank_d = (bcd_q[15:4] == 12'd0);
      default: blank_d = 1'b0;
    endcase
`else
    blank_d = 1'b0;
`endif
    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (blank_d) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_of(nib_d);
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign seg  = seg_d;
  assign an   = ~(4'b0001 << dig_q);

endmodule

// File: doc/bcd_seg_display.md
# bcd_seg_display

Display back end for the calculator datapath: accepts a 14-bit binary operand or result (the values the slider entry logic produces), converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a 4-digit, time-multiplexed, common-anode 7-segment display. Values above 9999 are flagged and shown as dashes. It is the consumer end of the entry path's number outputs.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; legal range ≥ 2.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- value  in  14  unsigned binary number to display
- value_valid  in  1  single-cycle load strobe for value
- busy  out  1  conversion in progress; value_valid ignored while high
- bcd  out  16  committed digits, [15:12] thousands … [3:0] ones
- ovf  out  1  committed value was > 9999
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low
- an  out  4  digit enables, active-low, an[0] = ones digit

## Operation
- FSM states:
  - IDLE: on value_valid, load value into a 14-bit shift register, clear the 20-bit internal BCD accumulator and the iteration counter (0..13), then go to CONV.
  - CONV: one iteration per cycle. First add 3 to every accumulator nibble ≥ 5, then shift {accumulator, shift register} left by 1.
  - After iteration 13: commit bcd ← accumulator[15:0] and ovf ← (accumulator[19:16] ≠ 0, or value > 9999), then return to IDLE.
- busy = (state == CONV).
- value_valid in CONV is dropped, not queued. value is sampled only on the load edge.
- bcd and ovf change only at commit. The display shows the old number for the whole conversion.
- Scan:
  - A refresh counter runs 0..REFRESH_DIV-1, then wraps.
  - On each wrap, the 2-bit digit index increments 0→1→2→3→0.
  - an is one-hot-low on the index, e.g. index 0 → 4'b1110, index 3 → 4'b0111.
- seg is combinational from the digit index, bcd and ovf:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles > 9 show blank, 1111111.
  - ovf=1 shows a dash, 0111111, on every digit.
- Reset values: state IDLE, busy 0, bcd 16'h0000, ovf 0, refresh counter 0, digit index 0, an 4'b1110, seg 1000000.
- Reset mid-conversion: the partial result is discarded and the outputs take their reset values on the next edge.

## Timing
- value_valid sampled high at edge N:
  - busy = 1 from after N until after N+14.
  - bcd/ovf update at edge N+14.
  - A new value_valid is accepted at edge N+14 at the earliest.
- Back-to-back strobes: throughput is one conversion per 14 cycles.
- Digit period is REFRESH_DIV cycles; full frame is 4·REFRESH_DIV cycles.
- an changes on the edge where the counter wraps from REFRESH_DIV-1 to 0.
- seg follows an in the same cycle, with no ghosting skew between them.
- Scanning is free-running and independent of busy.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Leading zero digits (thousands, hundreds, tens, scanned from the top) show blank, 1111111.
  - The ones digit is never blanked.
  - ovf dashes take priority over blanking.
  - The an timing is unchanged.
- Not defined: all four digits are always shown, zeros included.

## Test plan
- Reset, then hold 20 cycles → bcd=16'h0000, ovf=0, busy=0, an=4'b1110, seg=1000000.
- value=1234 with a 1-cycle value_valid → busy high for exactly 14 cycles; at N+14 bcd=16'h1234, ovf=0. Repeat with 9999 → 16'h9999 and with 0 → 16'h0000.
- value=10000, then 16383 → ovf=1 after 14 cycles; seg=0111111 on every digit across a full scan.
- value_valid with 4321 at N, then value_valid with 5555 at N+5 → second strobe ignored; bcd=16'h4321 at N+14. A strobe at N+14 converts normally.
- REFRESH_DIV=4 with bcd=16'h1234 → an cycles 1110, 1101, 1011, 0111 every 4 cycles; seg shows 4, 3, 2, 1 respectively.
- LEADING_ZERO_BLANK_EN with value=42 → digits 3 and 2 show 1111111, digit 1 shows 4, digit 0 shows 2. With value=0, only digit 0 shows 1000000. Rst asserted at N+7 of a conversion → next edge shows all reset values.
